// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl
// Countdown controller for the egg timer. Holds the mm:ss preset / running
// count as BCD digits, decrements once per tick_1hz while running, and
// sequences IDLE/RUN/PAUSE/ALARM from single-cycle button pulses.
//
// Parameters:
//   ALARM_SECS : ticks the alarm sounds before auto-return to IDLE (1..255)
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   tick_1hz   : one-cycle strobe per second
//   start_stop : start / pause / resume / silence pulse
//   clear      : return to IDLE at 00:00 from any state
//   inc_min    : minutes +1 (IDLE only, wraps 99->00)
//   inc_sec    : seconds +1 (IDLE only, wraps 59->00, no carry)
//   min_tens, min_ones, sec_tens, sec_ones : BCD display digits
//   gate_en    : registered enable for the downstream clock-gating stage
//   running    : high in RUN
//   alarm      : high in ALARM
module egg_timer_ctrl #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       gate_en,
  output logic       running,
  output logic       alarm
);

  localparam logic [7:0] ALARM_LIM = 8'(ALARM_SECS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    ALARM
  } state_t;

  state_t     state;
  logic [7:0] alarm_cnt;

  // Incremented and decremented digit candidates
  logic [3:0] mi_t, mi_o, si_t, si_o;
  logic [3:0] d_mt, d_mo, d_st, d_so;
  logic       time_zero;
  logic       dec_zero;
  logic [7:0] alarm_cnt_nxt;

  always_comb begin
    mi_t = min_tens;
    mi_o = min_ones + 4'd1;
    if (min_ones == 4'd9) begin
      mi_o = 4'd0;
      mi_t = (min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1;
    end

    si_t = sec_tens;
    si_o = sec_ones + 4'd1;
    if (sec_ones == 4'd9) begin
      si_o = 4'd0;
      si_t = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
    end

    // BCD borrow chain; only used while RUN, where time is never 00:00
    d_mt = min_tens;
    d_mo = min_ones;
    d_st = sec_tens;
    d_so = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      d_so = 4'd9;
      d_st = sec_tens - 4'd1;
      if (sec_tens == 4'd0) begin
        d_st = 4'd5;
        d_mo = min_ones - 4'd1;
        if (min_ones == 4'd0) begin
          d_mo = 4'd9;
          d_mt = min_tens - 4'd1;
        end
      end
    end

    time_zero     = ({min_tens, min_ones, sec_tens, sec_ones} == '0);
    dec_zero      = ({d_mt, d_mo, d_st, d_so} == '0);
    alarm_cnt_nxt = alarm_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      min_tens  <= '0;
      min_ones  <= '0;
      sec_tens  <= '0;
      sec_ones  <= '0;
      alarm_cnt <= '0;
      gate_en   <= 1'b0;
      running   <= 1'b0;
      alarm     <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      min_tens  <= '0;
      min_ones  <= '0;
      sec_tens  <= '0;
      sec_ones  <= '0;
      alarm_cnt <= '0;
      gate_en   <= 1'b0;
      running   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // start_stop outranks the edit pulses even when it is ignored
          if (start_stop) begin
            if (!time_zero) begin
              state   <= RUN;
              running <= 1'b1;
              gate_en <= 1'b1;
            end
          end else begin
            if (inc_min) begin
              min_tens <= mi_t;
              min_ones <= mi_o;
            end
            if (inc_sec) begin
              sec_tens <= si_t;
              sec_ones <= si_o;
            end
          end
        end

        RUN: begin
          if (start_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
            gate_en <= 1'b0;
          end else if (tick_1hz) begin
            min_tens <= d_mt;
            min_ones <= d_mo;
            sec_tens <= d_st;
            sec_ones <= d_so;
            if (dec_zero) begin
              state     <= ALARM;
              running   <= 1'b0;
              alarm     <= 1'b1;
              alarm_cnt <= '0;
            end
          end
        end

        PAUSE: begin
          if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
            gate_en <= 1'b1;
          end
        end

        ALARM: begin
          if (start_stop) begin
            state     <= IDLE;
            alarm     <= 1'b0;
            gate_en   <= 1'b0;
            alarm_cnt <= '0;
          end else if (tick_1hz) begin
            alarm_cnt <= alarm_cnt_nxt;
            if (alarm_cnt_nxt == ALARM_LIM) begin
              state   <= IDLE;
              alarm   <= 1'b0;
              gate_en <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
module tb_egg_timer_ctrl;

  localparam int unsigned ASECS = 10;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz, start_stop, clear, inc_min, inc_sec;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       gate_en, running, alarm;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: time as plain integers
  int m_mode = M_IDLE;
  int m_mins = 0;
  int m_secs = 0;
  int m_acnt = 0;

  egg_timer_ctrl #(.ALARM_SECS(ASECS)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .start_stop (start_stop),
    .clear      (clear),
    .inc_min    (inc_min),
    .inc_sec    (inc_sec),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .gate_en    (gate_en),
    .running    (running),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int t;
    t = m_mins * 60 + m_secs;
    chk({tag, ".min_tens"}, int'(min_tens), m_mins / 10);
    chk({tag, ".min_ones"}, int'(min_ones), m_mins % 10);
    chk({tag, ".sec_tens"}, int'(sec_tens), m_secs / 10);
    chk({tag, ".sec_ones"}, int'(sec_ones), m_secs % 10);
    chk({tag, ".running"}, int'(running), (m_mode == M_RUN) ? 1 : 0);
    chk({tag, ".alarm"}, int'(alarm), (m_mode == M_ALARM) ? 1 : 0);
    chk({tag, ".gate_en"}, int'(gate_en),
        (m_mode == M_RUN || m_mode == M_ALARM) ? 1 : 0);
    if (m_mode == M_ALARM) chk({tag, ".alarm_time"}, t, 0);
  endtask

  task automatic model_step(input bit c, input bit ss, input bit tk,
                            input bit im, input bit is);
    int t;
    if (c) begin
      m_mode = M_IDLE; m_mins = 0; m_secs = 0; m_acnt = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (ss) begin
            if (m_mins * 60 + m_secs != 0) m_mode = M_RUN;
          end else begin
            if (im) m_mins = (m_mins + 1) % 100;
            if (is) m_secs = (m_secs + 1) % 60;
          end
        end
        M_RUN: begin
          if (ss) m_mode = M_PAUSE;
          else if (tk) begin
            t = m_mins * 60 + m_secs - 1;
            m_mins = t / 60;
            m_secs = t % 60;
            if (t == 0) begin
              m_mode = M_ALARM;
              m_acnt = 0;
            end
          end
        end
        M_PAUSE: if (ss) m_mode = M_RUN;
        default: begin
          if (ss) m_mode = M_IDLE;
          else if (tk) begin
            m_acnt++;
            if (m_acnt == int'(ASECS)) m_mode = M_IDLE;
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, update model at the edge, check 1 ns later
  task automatic step(input string tag, input bit c, input bit ss,
                      input bit tk, input bit im, input bit is);
    clear = c; start_stop = ss; tick_1hz = tk; inc_min = im; inc_sec = is;
    @(posedge clk);
    model_step(c, ss, tk, im, is);
    #1;
    clear = 1'b0; start_stop = 1'b0; tick_1hz = 1'b0;
    inc_min = 1'b0; inc_sec = 1'b0;
    check_model(tag);
  endtask

  task automatic chk_time(input string tag, input int mm, input int ss);
    chk({tag, ".mm"}, int'(min_tens) * 10 + int'(min_ones), mm);
    chk({tag, ".ss"}, int'(sec_tens) * 10 + int'(sec_ones), ss);
  endtask

  initial begin
    int r;
    reset = 1'b1;
    clear = 1'b0; start_stop = 1'b0; tick_1hz = 1'b0;
    inc_min = 1'b0; inc_sec = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b0;

    // Editing and wrap
    repeat (3) step("inc_min", 0, 0, 0, 1, 0);
    repeat (61) step("inc_sec", 0, 0, 0, 0, 1);
    chk_time("edit_0301", 3, 1);
    repeat (97) step("min_wrap", 0, 0, 0, 1, 0);
    chk_time("edit_0001", 0, 1);

    // Countdown with borrow and expiry
    step("clr1", 1, 0, 0, 0, 0);
    step("set_0100", 0, 0, 0, 1, 0);
    step("go", 0, 1, 0, 0, 0);
    step("borrow", 0, 0, 1, 0, 0);
    chk_time("borrow_0059", 0, 59);
    repeat (58) step("count", 0, 0, 1, 0, 0);
    chk_time("count_0001", 0, 1);
    chk("count_running", int'(running), 1);
    step("expire", 0, 0, 1, 0, 0);
    chk("expire_alarm", int'(alarm), 1);
    chk("expire_gate", int'(gate_en), 1);
    repeat (ASECS - 1) step("alarm_hold", 0, 0, 1, 0, 0);
    chk("alarm_still", int'(alarm), 1);
    step("alarm_end", 0, 0, 1, 0, 0);
    chk("alarm_done", int'(alarm), 0);
    chk("alarm_done_gate", int'(gate_en), 0);

    // Pause with coincident tick
    step("clr2", 1, 0, 0, 0, 0);
    repeat (10) step("set_0010", 0, 0, 0, 0, 1);
    step("go2", 0, 1, 0, 0, 0);
    step("pause_coll", 0, 1, 1, 0, 0);
    chk_time("pause_0010", 0, 10);
    chk("pause_gate", int'(gate_en), 0);
    repeat (5) step("pause_tick", 0, 0, 1, 0, 0);
    chk_time("pause_frozen", 0, 10);
    step("resume", 0, 1, 0, 0, 0);
    chk("resume_running", int'(running), 1);

    // Priority and guards
    step("clr3", 1, 0, 0, 0, 0);
    repeat (5) step("set_05", 0, 0, 0, 1, 0);
    repeat (30) step("set_30", 0, 0, 0, 0, 1);
    step("go3", 0, 1, 0, 0, 0);
    step("clr_ss", 1, 1, 0, 0, 0);
    chk_time("clr_ss_0000", 0, 0);
    step("ss_zero", 0, 1, 0, 0, 0);
    chk("ss_zero_run", int'(running), 0);
    step("set_01", 0, 0, 0, 0, 1);
    step("go4", 0, 1, 0, 0, 0);
    step("inc_in_run", 0, 0, 0, 1, 1);
    chk_time("inc_in_run_t", 0, 1);

    // Async reset mid-ALARM
    step("to_alarm", 0, 0, 1, 0, 0);
    chk("to_alarm_a", int'(alarm), 1);
    #2 reset = 1'b1;
    #1;
    m_mode = M_IDLE; m_mins = 0; m_secs = 0; m_acnt = 0;
    check_model("async_reset");
    #1 reset = 1'b0;
    step("post_reset_inc", 0, 0, 0, 0, 1);
    chk_time("post_reset_0001", 0, 1);

    // Random stimulus against the model; one event class per cycle
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       step("rnd", 1, 0, 0, 0, 0);
      else if (r < 10) step("rnd", 0, 1, 0, 0, 0);
      else if (r < 60) step("rnd", 0, 0, 1, 0, 0);
      else if (r < 70) step("rnd", 0, 0, 0, 1, 0);
      else if (r < 88) step("rnd", 0, 0, 0, 0, 1);
      else if (r < 92) step("rnd", 0, 0, 0, 1, 1);
      else             step("rnd", 0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
